param_register_file: RTL and testbench

Parametrised successor to the single-write-port register file for the pipelined datapath. Provides two asynchronous read ports and two synchronous write ports with fixed write-port priority. Also provides an optional hard-wired zero register and optional write-to-read bypass. Contents are hardware-cleared by a sequential clear engine after reset; no file preload.

---
 rtl/param_register_file.sv | 132 +++++++++++++
 tb/tb_param_register_file.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Parametrised register file: two asynchronous read ports, two synchronous
// write ports (port B wins on an address collision), optional hard-wired
// zero entry, optional same-cycle write-to-read forwarding. The array is
// cleared by a sequential engine after reset; ready rises once every entry
// has been written with zero.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg2,
    input  logic [DATA_WIDTH-1:0] write_data2,
    input  logic                  reg_write2,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    run;
    logic                    we_a;
    logic                    we_b;
    logic [DATA_WIDTH-1:0]   arr1;
    logic [DATA_WIDTH-1:0]   arr2;

    // Whether an address refers to the hard-wired zero entry.
    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Resolve one read port: forced zero while clearing or for the zero
    // entry, then port B forwarding, then port A forwarding, then the array.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic                  running,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] arr,
        input logic                  wea,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wda,
        input logic                  web,
        input logic [ADDR_WIDTH-1:0] wb,
        input logic [DATA_WIDTH-1:0] wdb
    );
        if (!running || is_zero(a))
            return '0;
        if ((BYPASS != 0) && web && (wb == a))
            return wdb;
        if ((BYPASS != 0) && wea && (wa == a))
            return wda;
        return arr;
    endfunction

    assign run   = ready_q;
    assign ready = ready_q;

    // Port A is dropped when port B targets the same entry; neither port may
    // touch the zero entry.
    assign we_a = run && reg_write && !is_zero(write_reg)
                  && !(reg_write2 && (write_reg2 == write_reg));
    assign we_b = run && reg_write2 && !is_zero(write_reg2);

    assign arr1 = mem_q[read_reg1];
    assign arr2 = mem_q[read_reg2];

    // Combinational read ports with optional forwarding.
    always_comb begin
        read_data1 = resolve(run, read_reg1, arr1, reg_write, write_reg, write_data,
                             reg_write2, write_reg2, write_data2);
        read_data2 = resolve(run, read_reg2, arr2, reg_write, write_reg, write_data,
                             reg_write2, write_reg2, write_data2);
    end

    // Clear engine: walks cnt over every entry once after reset, then runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zeroed entry by entry while clearing, written in run;
    // left untouched while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (we_a)
                    mem_q[write_reg] <= write_data;
                if (we_b)
                    mem_q[write_reg2] <= write_data2;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: instance 0 uses the defaults (32-bit data,
// 32 entries, zero register and forwarding on); instance 1 uses 16-bit data,
// 8 entries, zero register and forwarding off. Both see the same stimulus
// (instance 1 takes the low address/data bits). A behavioural model predicts
// each cycle's read data and ready; a monitor compares at the falling edge.
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rr1, rr2, wr, wr2;
    logic [31:0] wd, wd2;
    logic        we, we2;

    logic [31:0] rd1_a, rd2_a;
    logic        rdy_a;
    logic [15:0] rd1_b, rd2_b;
    logic        rdy_b;

    always #5 clk = ~clk;

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .read_reg1(rr1), .read_reg2(rr2),
        .read_data1(rd1_a), .read_data2(rd2_a),
        .write_reg(wr), .write_data(wd), .reg_write(we),
        .write_reg2(wr2), .write_data2(wd2), .reg_write2(we2),
        .ready(rdy_a)
    );

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .read_reg1(rr1[2:0]), .read_reg2(rr2[2:0]),
        .read_data1(rd1_b), .read_data2(rd2_b),
        .write_reg(wr[2:0]), .write_data(wd[15:0]), .reg_write(we),
        .write_reg2(wr2[2:0]), .write_data2(wd2[15:0]), .reg_write2(we2),
        .ready(rdy_b)
    );

    // ---------------- reference model ----------------
    logic [31:0] mem [2][32];
    int          clear_left [2];
    bit          mrdy [2];

    function automatic int amask(input int k);
        return (k == 0) ? 31 : 7;
    endfunction
    function automatic logic [31:0] dmask(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction
    function automatic bit zreg(input int k);
        return (k == 0);
    endfunction
    function automatic bit byp(input int k);
        return (k == 0);
    endfunction

    // Value a read port should show in the current cycle, before the edge.
    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] addr);
        int a, pa, pb;
        a  = int'(addr) & amask(k);
        pa = int'(wr)   & amask(k);
        pb = int'(wr2)  & amask(k);
        if (!mrdy[k]) return 32'h0;
        if (zreg(k) && a == 0) return 32'h0;
        if (byp(k) && we2 && pb == a) return wd2 & dmask(k);
        if (byp(k) && we && pa == a) return wd & dmask(k);
        return mem[k][a];
    endfunction

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step(input int k);
        int pa, pb;
        pa = int'(wr)  & amask(k);
        pb = int'(wr2) & amask(k);
        if (rst) begin
            clear_left[k] = amask(k) + 1;
            mrdy[k] = 1'b0;
        end else if (!mrdy[k]) begin
            clear_left[k]--;
            if (clear_left[k] == 0) begin
                mrdy[k] = 1'b1;
                for (int i = 0; i < 32; i++) mem[k][i] = 32'h0;
            end
        end else begin
            if (we && !(zreg(k) && pa == 0) && !(we2 && pb == pa))
                mem[k][pa] = wd & dmask(k);
            if (we2 && !(zreg(k) && pb == 0))
                mem[k][pb] = wd2 & dmask(k);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] a1, a2, b1, b2;
        bit          ra, rb;
    } exp_t;

    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("ready_a", {31'h0, rdy_a}, {31'h0, e.ra});
            chk("ready_b", {31'h0, rdy_b}, {31'h0, e.rb});
            chk("rd1_a", rd1_a, e.a1);
            chk("rd2_a", rd2_a, e.a2);
            chk("rd1_b", {16'h0, rd1_b}, e.b1);
            chk("rd2_b", {16'h0, rd2_b}, e.b2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic e, input logic [4:0] w, input logic [31:0] d,
                       input logic e2, input logic [4:0] w2, input logic [31:0] d2);
        exp_t x;
        rst = r; rr1 = a1; rr2 = a2;
        we = e; wr = w; wd = d;
        we2 = e2; wr2 = w2; wd2 = d2;
        x.a1 = exp_rd(0, rr1);
        x.a2 = exp_rd(0, rr2);
        x.b1 = exp_rd(1, rr1);
        x.b2 = exp_rd(1, rr2);
        x.ra = mrdy[0];
        x.rb = mrdy[1];
        sbq.push_back(x);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(1'b0, a1, a2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rr1 = '0; rr2 = '0; we = 1'b0; wr = '0; wd = '0;
        we2 = 1'b0; wr2 = '0; wd2 = '0;
        mrdy[0] = 1'b0; mrdy[1] = 1'b0;
        clear_left[0] = 0; clear_left[1] = 0;
        for (int i = 0; i < 32; i++) begin mem[0][i] = '0; mem[1][i] = '0; end
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;

        // Reset held with writes requested; then clear while sweeping reads
        // and attempting writes that must not stick.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'(i), 5'(i), 1'b1, 5'(i + 5), 32'hCAFE0000 + i, 1'b1, 5'(i + 9), 32'hBEEF0000 + i);
        for (int i = 0; i < 34; i++)
            cyc(1'b0, 5'(i), 5'(31 - i), 1'b1, 5'(i), 32'h5A5A0000 + i, 1'b1, 5'(i + 1), 32'hA5A50000 + i);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // Single write with same-cycle read, then read back.
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd1, 32'h0000FFFF, 1'b0, 5'd0, 32'h0);
        idle(5'd1, 5'd1);

        // Collision at 30, then distinct addresses 3 and 4.
        cyc(1'b0, 5'd30, 5'd30, 1'b1, 5'd30, 32'h11111111, 1'b1, 5'd30, 32'hFFFF0000);
        idle(5'd30, 5'd30);
        cyc(1'b0, 5'd3, 5'd4, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444);
        idle(5'd3, 5'd4);

        // Zero register on both ports.
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF);
        idle(5'd0, 5'd0);

        // Narrow-instance write to entry 7.
        cyc(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 32'h0000A5A5, 1'b0, 5'd0, 32'h0);
        idle(5'd7, 5'd7);

        // Reset mid-operation and mid-clear, with writes during clear.
        cyc(1'b0, 5'd7, 5'd1, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'h0);
        idle(5'd7, 5'd7);
        cyc(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 9; i++)
            cyc(1'b0, 5'd7, 5'd1, 1'b1, 5'd7, 32'h77770000 + i, 1'b1, 5'd1, 32'h11110000 + i);
        cyc(1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 32'h87654321, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 34; i++)
            cyc(1'b0, 5'd7, 5'd1, 1'b1, 5'd7, 32'h99990000 + i, 1'b1, 5'd1, 32'h22220000 + i);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'd7);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 199) == 0), raddr(), raddr(),
                1'($urandom), raddr(), $urandom, 1'($urandom), raddr(), $urandom);
        for (int i = 0; i < 40; i++) idle(5'(i), raddr());

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
